// File: rtl/truth_table_sweeper_if.sv
// Bus between a sweep controller, the downstream N:1 multiplexer and the sweeper.
// The sweeper connects through the slave modport; the controller/mux side uses master.
`timescale 1ns/1ps
interface truth_table_sweeper_if #(
    parameter int SEL_W = 3
);
    localparam int N = 1 << SEL_W;

    logic             start;
    logic             abort;
    logic             f_in;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             done;
    logic [N-1:0]     tt;
    logic [SEL_W:0]   ones;

    modport master (
        output start, abort, f_in,
        input  sel, busy, done, tt, ones
    );

    modport slave (
        input  start, abort, f_in,
        output sel, busy, done, tt, ones
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Steps a multiplexer select through 0..N-1, capturing F at each setting into a
// truth table and counting its minterms; one sweep per accepted start.
`timescale 1ns/1ps
module truth_table_sweeper #(
    parameter int SEL_W = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    truth_table_sweeper_if.slave      bus
);
    localparam int N = 1 << SEL_W;
    localparam logic [SEL_W-1:0] LAST_SEL = {SEL_W{1'b1}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [SEL_W-1:0] sel_q;
    logic [N-1:0]     tt_q;
    logic [SEL_W:0]   ones_q;
    logic             busy_q;
    logic             done_q;

    // busy/done are flops of their own so they never glitch on state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            sel_q  <= '0;
            tt_q   <= '0;
            ones_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        state  <= S_SWEEP;
                        sel_q  <= '0;
                        tt_q   <= '0;
                        ones_q <= '0;
                        busy_q <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    // The current select is always captured, even on the abort cycle.
                    tt_q[sel_q] <= bus.f_in;
                    ones_q      <= ones_q + (SEL_W+1)'(bus.f_in);
                    if (bus.abort) begin
                        state  <= S_IDLE;
                        sel_q  <= '0;
                        busy_q <= 1'b0;
                    end else if (sel_q == LAST_SEL) begin
                        state  <= S_DONE;
                        sel_q  <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        sel_q <= sel_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    sel_q  <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel  = sel_q;
    assign bus.tt   = tt_q;
    assign bus.ones = ones_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised bench for truth_table_sweeper: a behavioural mux plus a table/popcount
// reference model, exercising both an 8-entry and a 4-entry instance.
`timescale 1ns/1ps
module tb_truth_table_sweeper;
    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] mux3;
    logic [3:0] mux2;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    truth_table_sweeper_if #(.SEL_W(3)) bus3 ();
    truth_table_sweeper_if #(.SEL_W(2)) bus2 ();

    assign bus3.f_in = mux3[bus3.sel];
    assign bus2.f_in = mux2[bus2.sel];

    truth_table_sweeper #(.SEL_W(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
    truth_table_sweeper #(.SEL_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // Reference: a full sweep reproduces the mux inputs; ones is their popcount.
    function automatic int popcount(input logic [7:0] v);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(v[i]);
        return c;
    endfunction

    // Reference for a sweep cut short after select k was captured.
    function automatic logic [7:0] partial_table(input logic [7:0] table_in, input int k);
        logic [7:0] mask;
        mask = 8'hFF >> (7 - k);
        return table_in & mask;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus3.start = 1'b0; bus3.abort = 1'b0;
        bus2.start = 1'b0; bus2.abort = 1'b0;
        mux3 = '0; mux2 = '0;
        #1;
        checks++;
        if ({bus3.busy, bus3.done, bus3.sel, bus3.tt, bus3.ones} !== 17'd0) begin
            failures++;
            $display("[TB] FAIL reset3 busy=%b done=%b sel=%0d tt=%h ones=%0d required all zero",
                     bus3.busy, bus3.done, bus3.sel, bus3.tt, bus3.ones);
        end
        checks++;
        if ({bus2.busy, bus2.done, bus2.sel, bus2.tt, bus2.ones} !== 11'd0) begin
            failures++;
            $display("[TB] FAIL reset2 busy=%b done=%b sel=%0d tt=%h ones=%0d required all zero",
                     bus2.busy, bus2.done, bus2.sel, bus2.tt, bus2.ones);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_sweep3(input logic [7:0] pattern, input string name);
        int exp_ones;
        logic [7:0] held_tt;
        exp_ones = popcount(pattern);
        mux3 = pattern;
        @(negedge clk);
        bus3.start = 1'b1;
        @(posedge clk);
        #1 bus3.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({bus3.busy, bus3.done, bus3.sel} !== {1'b1, 1'b0, 3'(k)}) begin
                failures++;
                $display("[TB] FAIL %s_step%0d busy=%b done=%b sel=%0d required busy=1 done=0 sel=%0d",
                         name, k, bus3.busy, bus3.done, bus3.sel, k);
            end
        end
        @(negedge clk);
        checks++;
        if ({bus3.busy, bus3.done, bus3.sel} !== {1'b0, 1'b1, 3'd0}) begin
            failures++;
            $display("[TB] FAIL %s_done busy=%b done=%b sel=%0d required busy=0 done=1 sel=0",
                     name, bus3.busy, bus3.done, bus3.sel);
        end
        checks++;
        if (bus3.tt !== pattern || int'(bus3.ones) != exp_ones) begin
            failures++;
            $display("[TB] FAIL %s_result tt=%h ones=%0d required tt=%h ones=%0d",
                     name, bus3.tt, bus3.ones, pattern, exp_ones);
        end
        held_tt = bus3.tt;
        @(negedge clk);
        checks++;
        if (bus3.done !== 1'b0 || bus3.busy !== 1'b0 || bus3.tt !== pattern || int'(bus3.ones) != exp_ones) begin
            failures++;
            $display("[TB] FAIL %s_after done=%b busy=%b tt=%h ones=%0d required done=0 busy=0 tt=%h ones=%0d",
                     name, bus3.done, bus3.busy, held_tt, bus3.ones, pattern, exp_ones);
        end
    endtask

    task automatic test_zero_ones();
        run_sweep3(8'h00, "all_zero");
        repeat (2) @(negedge clk);
        checks++;
        if (bus3.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL between_runs busy=%b required 0", bus3.busy);
        end
        run_sweep3(8'hFF, "all_one");
    endtask

    task automatic test_start_held();
        int done_cycles[$];
        int overlap = 0;
        mux3 = 8'hE8;
        @(negedge clk);
        bus3.start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus3.done) begin
                done_cycles.push_back(c);
                checks++;
                if (bus3.tt !== 8'hE8 || bus3.ones !== 4'd4) begin
                    failures++;
                    $display("[TB] FAIL held_result tt=%h ones=%0d required tt=e8 ones=4", bus3.tt, bus3.ones);
                end
            end
            if (bus3.done && bus3.busy) overlap++;
        end
        bus3.start = 1'b0;
        // A sweep takes 8 cycles, then DONE and one IDLE cycle before restart.
        checks++;
        if (done_cycles.size() != 4 || done_cycles[0] != 8) begin
            failures++;
            $display("[TB] FAIL held_count dones=%0d required 4 (first at cycle 8)", done_cycles.size());
        end
        for (int i = 1; i < done_cycles.size(); i++) begin
            checks++;
            if (done_cycles[i] - done_cycles[i-1] != 10) begin
                failures++;
                $display("[TB] FAIL held_period gap=%0d required 10", done_cycles[i] - done_cycles[i-1]);
            end
        end
        checks++;
        if (overlap != 0) begin
            failures++;
            $display("[TB] FAIL held_overlap cycles=%0d required 0", overlap);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus3.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL held_release busy=%b required 0", bus3.busy);
        end
    endtask

    task automatic test_abort(input logic [7:0] pattern, input int k);
        logic [7:0] exp_tt;
        int seen = 0;
        exp_tt = partial_table(pattern, k);
        mux3 = pattern;
        @(negedge clk);
        bus3.start = 1'b1;
        @(posedge clk);
        #1 bus3.start = 1'b0;
        for (int i = 0; i <= k; i++) @(negedge clk);
        bus3.abort = 1'b1;
        @(posedge clk);
        #1 bus3.abort = 1'b0;
        checks++;
        if ({bus3.busy, bus3.done, bus3.sel} !== 5'd0 || bus3.tt !== exp_tt || int'(bus3.ones) != popcount(exp_tt)) begin
            failures++;
            $display("[TB] FAIL abort_k%0d busy=%b done=%b sel=%0d tt=%h ones=%0d required 0/0/0 tt=%h ones=%0d",
                     k, bus3.busy, bus3.done, bus3.sel, bus3.tt, bus3.ones, exp_tt, popcount(exp_tt));
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus3.done || bus3.busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("[TB] FAIL abort_quiet active_cycles=%0d required 0", seen);
        end
    endtask

    task automatic test_abort_beats_start();
        logic [7:0] prev_tt;
        int seen = 0;
        prev_tt = bus3.tt;
        @(negedge clk);
        bus3.start = 1'b1;
        bus3.abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus3.busy || bus3.done) seen++;
        end
        bus3.start = 1'b0;
        bus3.abort = 1'b0;
        checks++;
        if (seen != 0 || bus3.tt !== prev_tt) begin
            failures++;
            $display("[TB] FAIL abort_start_idle active=%0d tt=%h required active=0 tt=%h", seen, bus3.tt, prev_tt);
        end
    endtask

    task automatic test_async_reset();
        int seen = 0;
        mux3 = 8'($urandom);
        @(negedge clk);
        bus3.start = 1'b1;
        @(posedge clk);
        #1 bus3.start = 1'b0;
        for (int i = 0; i <= 5; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus3.busy, bus3.done, bus3.sel, bus3.tt, bus3.ones} !== 17'd0) begin
            failures++;
            $display("[TB] FAIL async_reset busy=%b done=%b sel=%0d tt=%h ones=%0d required all zero",
                     bus3.busy, bus3.done, bus3.sel, bus3.tt, bus3.ones);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus3.done || bus3.busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("[TB] FAIL reset_discard active_cycles=%0d required 0", seen);
        end
        run_sweep3(8'h96, "after_reset");
    endtask

    task automatic run_sweep2(input logic [3:0] pattern, input string name);
        int exp_ones;
        exp_ones = popcount({4'd0, pattern});
        mux2 = pattern;
        @(negedge clk);
        bus2.start = 1'b1;
        @(posedge clk);
        #1 bus2.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({bus2.busy, bus2.done, bus2.sel} !== {1'b1, 1'b0, 2'(k)}) begin
                failures++;
                $display("[TB] FAIL %s_step%0d busy=%b done=%b sel=%0d required busy=1 done=0 sel=%0d",
                         name, k, bus2.busy, bus2.done, bus2.sel, k);
            end
        end
        @(negedge clk);
        checks++;
        if (bus2.done !== 1'b1 || bus2.busy !== 1'b0 || bus2.tt !== pattern || int'(bus2.ones) != exp_ones) begin
            failures++;
            $display("[TB] FAIL %s_done done=%b busy=%b tt=%h ones=%0d required done=1 busy=0 tt=%h ones=%0d",
                     name, bus2.done, bus2.busy, bus2.tt, bus2.ones, pattern, exp_ones);
        end
        @(negedge clk);
        checks++;
        if (bus2.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_pulse done=%b required 0", name, bus2.done);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        run_sweep3(8'h96, "xor3");
        test_zero_ones();
        test_start_held();
        test_abort(8'hFF, 3);
        test_abort(8'($urandom), int'($urandom_range(0, 6)));
        test_abort_beats_start();
        test_async_reset();
        for (int i = 0; i < 5; i++) run_sweep3(8'($urandom), "random3");
        run_sweep2(4'b1000, "and2");
        for (int i = 0; i < 3; i++) run_sweep2(4'($urandom), "random2");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter SEL_W, default 3, select width driven to the downstream multiplexer; table depth N = 2**SEL_W.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request one full sweep; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1, synchronous cancel of a sweep in progress.
REQ-006 SHALL have port f_in, input, 1, combinational output F of the downstream N:1 multiplexer.
REQ-007 SHALL have port sel, output, SEL_W, registered select driven to the multiplexer S input.
REQ-008 SHALL have port busy, output, 1, high while a sweep is in progress.
REQ-009 SHALL have port done, output, 1, single-cycle pulse when a sweep completes.
REQ-010 SHALL have port tt, output, N, captured truth table; bit k = F sampled with sel == k.
REQ-011 SHALL have port ones, output, SEL_W+1, count of minterms (ones in tt).

Function
REQ-012 SHALL implement FSM states IDLE, SWEEP, DONE.
REQ-013 IDLE, start=1: next edge -> SWEEP; sel<=0, tt<=0, ones<=0, busy<=1.
REQ-014 IDLE, start=0: hold state; sel, tt, ones keep last values.
REQ-015 SWEEP each cycle: tt[sel]<=f_in; ones<=ones+f_in; f_in sampled in the same cycle sel holds that value.
REQ-016 SWEEP, sel < N-1: sel<=sel+1, stay in SWEEP.
REQ-017 SWEEP, sel == N-1: capture last bit, sel<=0 (no wrap beyond N-1), -> DONE.
REQ-018 DONE: done=1 and busy=0 for exactly one cycle, then unconditionally -> IDLE.
REQ-019 Latency: start accepted at edge E0; done high during the cycle after edge E0+N; SWEEP occupies exactly N cycles.
REQ-020 start while busy or in DONE SHALL be ignored (no restart, no queuing).
REQ-021 abort=1 in SWEEP: next edge -> IDLE, busy<=0, sel<=0, done stays 0; tt/ones hold partial values.
REQ-022 abort in IDLE or DONE SHALL have no effect; abort and start both high in IDLE: abort wins, stay IDLE.
REQ-023 ones SHALL never overflow: max value N fits in SEL_W+1 bits.
REQ-024 tt and ones SHALL be stable and valid from the done cycle until the next accepted start.
REQ-025 done and busy SHALL be registered (decoded from state registers), glitch-free.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, sel=0, tt=0, ones=0, busy=0, done=0, independent of clk.
REQ-027 Reset mid-SWEEP SHALL discard the sweep; no done pulse after rst_n release.
REQ-028 First start SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-029 Mux I=8'b1001_0110 (XOR3), pulse start -> sel steps 0..7 over 8 cycles, done pulse, tt=8'h96, ones=4.
REQ-030 Mux I=8'h00 then I=8'hFF, two sweeps -> tt=8'h00, ones=0; then tt=8'hFF, ones=8; busy low between runs.
REQ-031 start held high continuously with I=8'hE8 (majority) -> one sweep per IDLE visit, each done yields tt=8'hE8, ones=4; no start accepted while busy.
REQ-032 abort asserted when sel=3 with I=8'hFF -> next edge IDLE, busy=0, no done, tt=8'h0F, ones=4.
REQ-033 rst_n pulled low asynchronously mid-sweep (sel=5) -> outputs zero immediately; after release no done; fresh sweep with I=8'h96 -> tt=8'h96.
REQ-034 Parameter SEL_W=2, I=4'b1000 (AND2) -> 4-cycle sweep, tt=4'h8, ones=1.
